bus_responder: RTL and testbench
================================

// Module: bus_responder
// PURPOSE
//  - Target-side end of the CPU address/data bus.
//  - Samples the address the core drives (valid at fclk with q==2'b00, be high), decodes it into a memory region,
//    inserts per-region wait states and holds rdy low until the selected device completes a req/ack handshake.
//  - Returns read data (or the unmapped fill byte) to the core's input data latch.
//  - Sits between the core bus pins and the RAM/IO/ROM device ports.
// PARAMETERS
//  RAM_WS   0   wait-state cycles inserted before dev_req for the RAM region
//  IO_WS    2   wait-state cycles for the IO region
//  ROM_WS   1   wait-state cycles for the ROM region
//  TIMEOUT  16  cycles from dev_req rise to forced abort (used only with BUS_TIMEOUT_EN)
// PORTS
//  fclk       in   1   system clock; all state changes on its rising edge
//  resb       in   1   synchronous active-low reset
//  q          in   2   bus phase counter; 2'b00 = address valid, 2'b11 = last phase
//  be         in   1   bus enable; low = address bus floated, ignore
//  rwb        in   1   1 = read, 0 = write
//  addr_in    in   16  address from core
//  data_in    in   8   write data from core
//  data_out   out  8   read data to core
//  data_oe    out  1   high while data_out is valid for a read
//  rdy        out  1   low = stretch current bus cycle
//  dev_sel    out  3   one-hot region select {ROM,IO,RAM}, held during access
//  dev_req    out  1   device request, level, held until dev_ack
//  dev_we     out  1   write strobe qualifier (~rwb captured)
//  dev_addr   out  16  captured address
//  dev_wdata  out  8   captured write data
//  dev_rdata  in   8   device read data, valid with dev_ack
//  dev_ack    in   1   device completion, single-cycle pulse
//  bus_err    out  1   sticky timeout flag
// BEHAVIOUR
//  - Reset (resb==0 at a fclk edge):
//    - state=IDLE; rdy=1; data_oe=0; data_out=8'h00; dev_req=0; dev_sel=0; dev_we=0; dev_addr=0; dev_wdata=0; bus_err=0.
//  - FSM IDLE->WAIT->ACCESS->HOLD->IDLE.
//  - IDLE: start = (q==2'b00 && be). On start:
//    - capture addr_in, rwb, data_in; decode region; rdy<=0.
//    - Wait counter loads the region WS.
//    - Unmapped: data_out<=8'hFF, go HOLD.
//    - WS==0: go ACCESS.
//    - Otherwise: go WAIT.
//  - WAIT: decrement the counter each cycle. At count 1, go ACCESS. WAIT lasts exactly WS cycles.
//  - ACCESS: dev_req=1, dev_sel=region, dev_we=~rwb_cap.
//    - On dev_ack (may arrive in the first ACCESS cycle): dev_req<=0, dev_sel<=0.
//    - If read: data_out<=dev_rdata.
//    - Go HOLD.
//  - HOLD: rdy=1. data_oe = rwb_cap. At the first cycle with q==2'b11, data_oe<=0 and go IDLE.
//  - Latency: start at edge T0. dev_req is high from T0+1+WS. An ack at edge Ta gives rdy=1 and data valid from Ta+1.
//  - Start conditions while not IDLE are ignored; the core holds the address while rdy is low.
//  - be falling mid-access does not abort; the access completes normally.
//  - dev_ack outside ACCESS is ignored.
//  - Decode (inclusive): RAM 16'h0000-7FFF, IO 16'hD000-DFFF, ROM 16'hE000-FFFF; anything else is unmapped.
//  - Writes to ROM go through the handshake normally; the device decides what to do with them.
//  - Reset mid-operation: immediate return to IDLE; dev_req drops in the same edge.
// CONFIGURATION
//  - Macro BUS_TIMEOUT_EN defined:
//    - An 8-bit counter runs while in ACCESS.
//    - After TIMEOUT cycles without dev_ack: dev_req<=0, data_out<=8'hFF, bus_err<=1 (sticky until reset), go HOLD.
//  - Macro not defined:
//    - ACCESS waits indefinitely; bus_err is tied to 0; no timeout counter logic exists.
// STRUCTURE
//  - Package bus_pkg:
//    - region_t enum {REG_NONE, REG_RAM, REG_IO, REG_ROM}.
//    - Base/limit localparams for each region.
//    - FILL_BYTE = 8'hFF.
//    - state_t enum {IDLE, WAIT, ACCESS, HOLD}.
//  - Sub-module bus_region_decode: combinational addr[15:0] -> region_t, plus the one-hot sel.
//  - The FSM, wait counter and timeout counter live in bus_responder.
// TESTING
//  - RAM read: addr 16'h0010, rwb=1, dev_ack in the first ACCESS cycle with rdata 8'hA5
//    -> dev_req high 1 cycle after start, rdy low for 2 cycles, data_out=8'hA5 with data_oe=1.
//  - IO write, IO_WS=2: addr 16'hD003, data 8'h3C
//    -> dev_req rises 3 cycles after start with dev_we=1, dev_wdata=8'h3C, dev_sel=3'b010; data_oe stays 0.
//  - Unmapped read at 16'hA000 -> no dev_req ever; data_out=8'hFF; rdy low exactly 1 cycle.
//  - Reset asserted while in ACCESS with dev_req=1 -> next edge: dev_req=0, rdy=1, state IDLE, bus_err=0.
//  - be=0 at q==2'b00 -> no capture, rdy stays 1. A second q==2'b00 while in WAIT -> ignored; captured address unchanged.
//  - BUS_TIMEOUT_EN, TIMEOUT=16, ROM read with no ack
//    -> after 16 ACCESS cycles: data_out=8'hFF, bus_err=1, and it stays 1 across later good cycles.

Source files
------------

// File: rtl/bus_pkg.sv
// Shared types and constants for the CPU bus responder: region/state enums,
// region address windows and the fill byte returned for unmapped reads.
package bus_pkg;

  typedef enum logic [1:0] {REG_NONE, REG_RAM, REG_IO, REG_ROM} region_t;
  typedef enum logic [1:0] {IDLE, WAIT, ACCESS, HOLD} state_t;

  localparam logic [15:0] RAM_BASE  = 16'h0000;
  localparam logic [15:0] RAM_LIMIT = 16'h7FFF;
  localparam logic [15:0] IO_BASE   = 16'hD000;
  localparam logic [15:0] IO_LIMIT  = 16'hDFFF;
  localparam logic [15:0] ROM_BASE  = 16'hE000;
  localparam logic [15:0] ROM_LIMIT = 16'hFFFF;

  localparam logic [2:0] SEL_RAM = 3'b001;
  localparam logic [2:0] SEL_IO  = 3'b010;
  localparam logic [2:0] SEL_ROM = 3'b100;

  localparam logic [7:0] FILL_BYTE = 8'hFF;

  // Offset compare keeps the test inclusive at both ends without constant-range compares.
  function automatic logic in_range(input logic [15:0] a,
                                    input logic [15:0] base,
                                    input logic [15:0] limit);
    logic [15:0] off;
    off = a - base;
    return off <= (limit - base);
  endfunction

endpackage

// File: rtl/bus_region_decode.sv
// Combinational address decoder: maps a 16-bit bus address to its region and
// the matching one-hot device select {ROM,IO,RAM}.
module bus_region_decode
  import bus_pkg::*;
(
  input  logic [15:0] addr,
  output region_t     region,
  output logic [2:0]  sel
);

  always_comb begin
    region = REG_NONE;
    sel    = 3'b000;
    if (in_range(addr, RAM_BASE, RAM_LIMIT)) begin
      region = REG_RAM;
      sel    = SEL_RAM;
    end else if (in_range(addr, IO_BASE, IO_LIMIT)) begin
      region = REG_IO;
      sel    = SEL_IO;
    end else if (in_range(addr, ROM_BASE, ROM_LIMIT)) begin
      region = REG_ROM;
      sel    = SEL_ROM;
    end
  end

endmodule

// File: rtl/bus_responder.sv
// Target-side bus responder: captures the core's address phase, inserts region wait
// states and runs a req/ack handshake. BUS_TIMEOUT_EN adds an ACCESS timeout with sticky bus_err.
module bus_responder
  import bus_pkg::*;
#(
  parameter int RAM_WS = 0,
  parameter int IO_WS  = 2,
  parameter int ROM_WS = 1
`ifdef BUS_TIMEOUT_EN
  ,
  parameter int TIMEOUT = 16
`endif
) (
  input  logic        fclk,
  input  logic        resb,
  input  logic [1:0]  q,
  input  logic        be,
  input  logic        rwb,
  input  logic [15:0] addr_in,
  input  logic [7:0]  data_in,
  output logic [7:0]  data_out,
  output logic        data_oe,
  output logic        rdy,
  output logic [2:0]  dev_sel,
  output logic        dev_req,
  output logic        dev_we,
  output logic [15:0] dev_addr,
  output logic [7:0]  dev_wdata,
  input  logic [7:0]  dev_rdata,
  input  logic        dev_ack,
  output logic        bus_err
);

  region_t    dec_region;
  logic [2:0] dec_sel;
  logic [7:0] region_ws;
  logic       enter_access;

  state_t      state_reg, state_next;
  logic [7:0]  ws_cnt_reg, ws_cnt_next;
  logic        rwb_reg, rwb_next;
  logic [2:0]  sel_cap_reg, sel_cap_next;
  logic [15:0] addr_reg, addr_next;
  logic [7:0]  wdata_reg, wdata_next;
  logic [7:0]  data_out_reg, data_out_next;
  logic        data_oe_reg, data_oe_next;
  logic        rdy_reg, rdy_next;
  logic        dev_req_reg, dev_req_next;
  logic [2:0]  dev_sel_reg, dev_sel_next;
  logic        dev_we_reg, dev_we_next;

`ifdef BUS_TIMEOUT_EN
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);
  logic [7:0] to_cnt_reg, to_cnt_next;
  logic       bus_err_reg, bus_err_next;
`endif

  bus_region_decode u_decode (
    .addr   (addr_in),
    .region (dec_region),
    .sel    (dec_sel)
  );

  always_comb begin
    case (dec_region)
      REG_RAM: region_ws = 8'(RAM_WS);
      REG_IO:  region_ws = 8'(IO_WS);
      REG_ROM: region_ws = 8'(ROM_WS);
      default: region_ws = 8'd0;
    endcase
  end

  always_comb begin
    state_next    = state_reg;
    ws_cnt_next   = ws_cnt_reg;
    rwb_next      = rwb_reg;
    sel_cap_next  = sel_cap_reg;
    addr_next     = addr_reg;
    wdata_next    = wdata_reg;
    data_out_next = data_out_reg;
    data_oe_next  = data_oe_reg;
    rdy_next      = rdy_reg;
    dev_req_next  = dev_req_reg;
    dev_sel_next  = dev_sel_reg;
    dev_we_next   = dev_we_reg;
    enter_access  = 1'b0;
`ifdef BUS_TIMEOUT_EN
    to_cnt_next   = to_cnt_reg;
    bus_err_next  = bus_err_reg;
`endif

    case (state_reg)
      IDLE: begin
        if (q == 2'b00 && be) begin
          addr_next    = addr_in;
          rwb_next     = rwb;
          wdata_next   = data_in;
          sel_cap_next = dec_sel;
          ws_cnt_next  = region_ws;
          rdy_next     = 1'b0;
          if (dec_region == REG_NONE) begin
            data_out_next = FILL_BYTE;
            state_next    = HOLD;
          end else if (region_ws == 8'd0) begin
            enter_access = 1'b1;
          end else begin
            state_next = WAIT;
          end
        end
      end
      WAIT: begin
        ws_cnt_next = ws_cnt_reg - 8'd1;
        if (ws_cnt_reg == 8'd1) enter_access = 1'b1;
      end
      ACCESS: begin
`ifdef BUS_TIMEOUT_EN
        to_cnt_next = to_cnt_reg + 8'd1;
`endif
        if (dev_ack) begin
          dev_req_next = 1'b0;
          dev_sel_next = 3'b000;
          dev_we_next  = 1'b0;
          if (rwb_reg) data_out_next = dev_rdata;
          state_next = HOLD;
        end
`ifdef BUS_TIMEOUT_EN
        else if (to_cnt_reg == TO_LAST) begin
          dev_req_next  = 1'b0;
          dev_sel_next  = 3'b000;
          dev_we_next   = 1'b0;
          data_out_next = FILL_BYTE;
          bus_err_next  = 1'b1;
          state_next    = HOLD;
        end
`endif
      end
      HOLD: begin
        rdy_next = 1'b1;
        if (q == 2'b11) begin
          data_oe_next = 1'b0;
          state_next   = IDLE;
        end else begin
          data_oe_next = rwb_reg;
        end
      end
      default: state_next = IDLE;
    endcase

    // Request outputs are registered so they are stable for the whole ACCESS state.
    if (enter_access) begin
      state_next   = ACCESS;
      dev_req_next = 1'b1;
      dev_sel_next = sel_cap_next;
      dev_we_next  = ~rwb_next;
`ifdef BUS_TIMEOUT_EN
      to_cnt_next  = 8'd0;
`endif
    end
  end

  always_ff @(posedge fclk) begin
    if (!resb) begin
      state_reg    <= IDLE;
      ws_cnt_reg   <= 8'd0;
      rwb_reg      <= 1'b0;
      sel_cap_reg  <= 3'b000;
      addr_reg     <= 16'h0000;
      wdata_reg    <= 8'h00;
      data_out_reg <= 8'h00;
      data_oe_reg  <= 1'b0;
      rdy_reg      <= 1'b1;
      dev_req_reg  <= 1'b0;
      dev_sel_reg  <= 3'b000;
      dev_we_reg   <= 1'b0;
    end else begin
      state_reg    <= state_next;
      ws_cnt_reg   <= ws_cnt_next;
      rwb_reg      <= rwb_next;
      sel_cap_reg  <= sel_cap_next;
      addr_reg     <= addr_next;
      wdata_reg    <= wdata_next;
      data_out_reg <= data_out_next;
      data_oe_reg  <= data_oe_next;
      rdy_reg      <= rdy_next;
      dev_req_reg  <= dev_req_next;
      dev_sel_reg  <= dev_sel_next;
      dev_we_reg   <= dev_we_next;
    end
  end

`ifdef BUS_TIMEOUT_EN
  always_ff @(posedge fclk) begin
    if (!resb) begin
      to_cnt_reg  <= 8'd0;
      bus_err_reg <= 1'b0;
    end else begin
      to_cnt_reg  <= to_cnt_next;
      bus_err_reg <= bus_err_next;
    end
  end
  assign bus_err = bus_err_reg;
`else
  assign bus_err = 1'b0;
`endif

  assign data_out  = data_out_reg;
  assign data_oe   = data_oe_reg;
  assign rdy       = rdy_reg;
  assign dev_sel   = dev_sel_reg;
  assign dev_req   = dev_req_reg;
  assign dev_we    = dev_we_reg;
  assign dev_addr  = addr_reg;
  assign dev_wdata = wdata_reg;

endmodule

// File: tb/tb_bus_responder.sv
// Bench for bus_responder: a timestamp-based transaction model checked every cycle,
// plus directed transactions with hand-computed latencies and data values.
module tb_bus_responder;

  logic        fclk = 1'b0;
  logic        resb;
  logic [1:0]  q;
  logic        be;
  logic        rwb;
  logic [15:0] addr_in;
  logic [7:0]  data_in;
  logic [7:0]  data_out;
  logic        data_oe;
  logic        rdy;
  logic [2:0]  dev_sel;
  logic        dev_req;
  logic        dev_we;
  logic [15:0] dev_addr;
  logic [7:0]  dev_wdata;
  logic [7:0]  dev_rdata;
  logic        dev_ack;
  logic        bus_err;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  always #5 fclk = ~fclk;

  bus_responder dut (
    .fclk      (fclk),
    .resb      (resb),
    .q         (q),
    .be        (be),
    .rwb       (rwb),
    .addr_in   (addr_in),
    .data_in   (data_in),
    .data_out  (data_out),
    .data_oe   (data_oe),
    .rdy       (rdy),
    .dev_sel   (dev_sel),
    .dev_req   (dev_req),
    .dev_we    (dev_we),
    .dev_addr  (dev_addr),
    .dev_wdata (dev_wdata),
    .dev_rdata (dev_rdata),
    .dev_ack   (dev_ack),
    .bus_err   (bus_err)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- model: each access described by edge timestamps ----------------
  int         ws_of [4]  = '{0, 0, 2, 1};
  logic [2:0] sel_of [4] = '{3'd0, 3'd1, 3'd2, 3'd4};

  function automatic int region_of(input logic [15:0] a);
    if (a <= 16'h7FFF) return 1;
    if (a >= 16'hD000 && a <= 16'hDFFF) return 2;
    if (a >= 16'hE000) return 3;
    return 0;
  endfunction

  bit          m_busy, m_rd, m_err;
  int          m_a, m_h, m_reg;
  logic [2:0]  m_sel;
  logic [7:0]  exp_dout, exp_wdata;
  logic [15:0] exp_addr;
  logic        exp_rdy, exp_oe, exp_req, exp_we;
  logic [2:0]  exp_sel;

  always @(posedge fclk) begin
    cyc++;
    if (!resb) begin
      m_busy = 0; m_rd = 0; m_err = 0; m_a = -1; m_h = -1; m_sel = 3'd0;
      exp_dout = 8'h00; exp_addr = 16'h0000; exp_wdata = 8'h00;
    end else if (!m_busy) begin
      if (q == 2'b00 && be) begin
        m_busy = 1; m_rd = rwb; exp_addr = addr_in; exp_wdata = data_in;
        m_reg = region_of(addr_in);
        m_sel = sel_of[m_reg];
        if (m_reg == 0) begin
          m_a = -1; m_h = cyc; exp_dout = 8'hFF;
        end else begin
          m_a = cyc + ws_of[m_reg]; m_h = -1;
        end
      end
    end else if (m_h < 0) begin
      if (cyc > m_a && dev_ack) begin
        m_h = cyc;
        if (m_rd) exp_dout = dev_rdata;
      end
`ifdef BUS_TIMEOUT_EN
      else if (cyc == m_a + 16) begin
        m_h = cyc; exp_dout = 8'hFF; m_err = 1;
      end
`endif
    end else if (cyc > m_h && q == 2'b11) begin
      m_busy = 0;
    end
    exp_req = m_busy && m_h < 0 && cyc >= m_a;
    exp_sel = exp_req ? m_sel : 3'b000;
    exp_we  = exp_req && !m_rd;
    exp_rdy = !(m_busy && (m_h < 0 || cyc == m_h));
    exp_oe  = m_busy && m_h >= 0 && cyc > m_h && m_rd;
  end

  always @(negedge fclk) begin
    if (cyc > 0) begin
      chk("rdy",       32'(rdy),       32'(exp_rdy));
      chk("data_oe",   32'(data_oe),   32'(exp_oe));
      chk("data_out",  32'(data_out),  32'(exp_dout));
      chk("dev_req",   32'(dev_req),   32'(exp_req));
      chk("dev_sel",   32'(dev_sel),   32'(exp_sel));
      chk("dev_we",    32'(dev_we),    32'(exp_we));
      chk("dev_addr",  32'(dev_addr),  32'(exp_addr));
      chk("dev_wdata", 32'(dev_wdata), 32'(exp_wdata));
      chk("bus_err",   32'(bus_err),   32'(m_err));
    end
  end

  // ---------------- stimulus ----------------
  // mode 1: re-issue q==00 with a different address during WAIT; mode 2: drop be mid-access
  task automatic run_txn(input logic [15:0] a, input logic rd, input logic [7:0] wd,
                         input logic [7:0] rdv, input int ack_lat, input int mode,
                         output int req_rise, output int rdy_low, output logic [7:0] dout,
                         output logic oe, output logic [2:0] sel_r, output logic we_r,
                         output logic [15:0] addr_r, output logic oe_end);
    int  seen;
    bit  done;
    req_rise = -1; rdy_low = 0; seen = 0; done = 0;
    dout = 8'h00; oe = 1'b0; sel_r = 3'b000; we_r = 1'b0; addr_r = 16'h0000;
    q = 2'b00; be = 1'b1; addr_in = a; rwb = rd; data_in = wd;
    @(negedge fclk);
    q = 2'b01;
    for (int n = 1; n <= 40 && !done; n++) begin
      dev_ack = 1'b0;
      if (mode == 1 && n == 1) begin q = 2'b00; addr_in = 16'h0020; end
      if (mode == 1 && n == 2) begin q = 2'b01; addr_in = a; end
      if (mode == 2 && n == 1) be = 1'b0;
      if (rdy) begin
        done = 1; dout = data_out; oe = data_oe;
      end else begin
        rdy_low++;
        if (dev_req) begin
          if (req_rise < 0) begin
            req_rise = n; sel_r = dev_sel; we_r = dev_we; addr_r = dev_addr;
          end
          if (seen == ack_lat) begin dev_ack = 1'b1; dev_rdata = rdv; end
          seen++;
        end
        @(negedge fclk);
      end
    end
    dev_ack = 1'b0;
    chk("txn_done", 32'(done), 32'd1);
    q = 2'b11; be = 1'b0;
    @(negedge fclk);
    oe_end = data_oe;
    q = 2'b10;
  endtask

  logic [15:0] bnd_addr [7] = '{16'h7FFF, 16'h8000, 16'hCFFF, 16'hD000, 16'hDFFF, 16'hE000, 16'hFFFF};
  int          bnd_rise [7] = '{1, -1, -1, 3, 3, 2, 2};
  logic [2:0]  bnd_sel  [7] = '{3'b001, 3'b000, 3'b000, 3'b010, 3'b010, 3'b100, 3'b100};

  int          rise, low;
  logic [7:0]  dout, rv;
  logic        oe, we_r, oe_end;
  logic [2:0]  sel_r;
  logic [15:0] addr_r;

  initial begin
    resb = 1'b0; q = 2'b10; be = 1'b0; rwb = 1'b1; addr_in = 16'h0000;
    data_in = 8'h00; dev_rdata = 8'h00; dev_ack = 1'b0;
    repeat (2) @(negedge fclk);
    chk("rst_rdy",  32'(rdy),      32'd1);
    chk("rst_req",  32'(dev_req),  32'd0);
    chk("rst_dout", 32'(data_out), 32'h00);
    chk("rst_sel",  32'(dev_sel),  32'd0);
    resb = 1'b1;
    @(negedge fclk);

    // be low during q==00 is not an address phase; a stray ack in IDLE is ignored
    q = 2'b00; be = 1'b0; addr_in = 16'h0010;
    repeat (2) @(negedge fclk);
    chk("be0_rdy", 32'(rdy), 32'd1);
    q = 2'b10; dev_ack = 1'b1;
    @(negedge fclk);
    dev_ack = 1'b0;
    chk("idle_ack_rdy", 32'(rdy), 32'd1);

    run_txn(16'h0010, 1'b1, 8'h00, 8'hA5, 0, 0, rise, low, dout, oe, sel_r, we_r, addr_r, oe_end);
    chk("ram_rd_rise", 32'(rise), 32'd1);
    chk("ram_rd_low",  32'(low),  32'd2);
    chk("ram_rd_dout", 32'(dout), 32'hA5);
    chk("ram_rd_oe",   32'(oe),   32'd1);
    chk("ram_rd_oe_end", 32'(oe_end), 32'd0);

    run_txn(16'hD003, 1'b0, 8'h3C, 8'h00, 0, 0, rise, low, dout, oe, sel_r, we_r, addr_r, oe_end);
    chk("io_wr_rise",  32'(rise),      32'd3);
    chk("io_wr_we",    32'(we_r),      32'd1);
    chk("io_wr_sel",   32'(sel_r),     32'b010);
    chk("io_wr_wdata", 32'(dev_wdata), 32'h3C);
    chk("io_wr_oe",    32'(oe),        32'd0);
    chk("io_wr_low",   32'(low),       32'd4);

    run_txn(16'hA000, 1'b1, 8'h00, 8'h00, 0, 0, rise, low, dout, oe, sel_r, we_r, addr_r, oe_end);
    chk("unm_rise", 32'(rise), 32'(-1));
    chk("unm_dout", 32'(dout), 32'hFF);
    chk("unm_low",  32'(low),  32'd1);

    run_txn(16'hE004, 1'b0, 8'h99, 8'h00, 1, 0, rise, low, dout, oe, sel_r, we_r, addr_r, oe_end);
    chk("rom_wr_rise", 32'(rise), 32'd2);
    chk("rom_wr_we",   32'(we_r), 32'd1);

    run_txn(16'hD010, 1'b1, 8'h00, 8'h5E, 0, 1, rise, low, dout, oe, sel_r, we_r, addr_r, oe_end);
    chk("wait_restart_addr", 32'(addr_r), 32'hD010);
    chk("wait_restart_dout", 32'(dout),   32'h5E);

    run_txn(16'h0200, 1'b1, 8'h00, 8'hC3, 2, 2, rise, low, dout, oe, sel_r, we_r, addr_r, oe_end);
    chk("be_drop_dout", 32'(dout), 32'hC3);
    chk("be_drop_low",  32'(low),  32'd4);

    for (int i = 0; i < 7; i++) begin
      rv = 8'(8'h40 + i);
      run_txn(bnd_addr[i], 1'b1, 8'h00, rv, 0, 0, rise, low, dout, oe, sel_r, we_r, addr_r, oe_end);
      chk("bnd_rise", 32'(rise),  32'(bnd_rise[i]));
      chk("bnd_sel",  32'(sel_r), 32'(bnd_sel[i]));
      chk("bnd_dout", 32'(dout),  32'((bnd_rise[i] < 0) ? 8'hFF : rv));
    end

    // reset while the RAM request is outstanding
    q = 2'b00; be = 1'b1; addr_in = 16'h0100; rwb = 1'b0; data_in = 8'h77;
    @(negedge fclk);
    q = 2'b01;
    chk("mid_rst_req_before", 32'(dev_req), 32'd1);
    resb = 1'b0;
    @(negedge fclk);
    chk("mid_rst_req", 32'(dev_req), 32'd0);
    chk("mid_rst_rdy", 32'(rdy),     32'd1);
    chk("mid_rst_err", 32'(bus_err), 32'd0);
    resb = 1'b1; q = 2'b10; be = 1'b0;
    @(negedge fclk);

    run_txn(16'h0300, 1'b1, 8'h00, 8'h6B, 1, 0, rise, low, dout, oe, sel_r, we_r, addr_r, oe_end);
    chk("post_rst_dout", 32'(dout), 32'h6B);

`ifdef BUS_TIMEOUT_EN
    run_txn(16'hF000, 1'b1, 8'h00, 8'h00, 1000, 0, rise, low, dout, oe, sel_r, we_r, addr_r, oe_end);
    chk("to_rise", 32'(rise),    32'd2);
    chk("to_low",  32'(low),     32'd18);
    chk("to_dout", 32'(dout),    32'hFF);
    chk("to_err",  32'(bus_err), 32'd1);
    run_txn(16'h0010, 1'b1, 8'h00, 8'h12, 0, 0, rise, low, dout, oe, sel_r, we_r, addr_r, oe_end);
    chk("to_err_sticky", 32'(bus_err), 32'd1);
    chk("to_after_dout", 32'(dout),    32'h12);
`endif

    repeat (2) @(negedge fclk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not reach the end, errors so far %0d", n_errors);
    $fatal(1);
  end

endmodule
